// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller, the peripheral request lines and the core.
// The controller uses the slave view; the core side and the bench use the master view.
interface interrupt_controller_if #(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 3
);
   logic [NUM_IRQ-1:0] irq;
   logic [NUM_IRQ-1:0] mask;
   logic               nmi_req;
   logic               INA;
   logic               eoi;
   logic               INT;
   logic               NMI;
   logic               INTD;
   logic               in_service;
   logic [VEC_W-1:0]   active_vec;

   modport slave (
      input  irq, mask, nmi_req, INA, eoi,
      output INT, NMI, INTD, in_service, active_vec
   );

   modport master (
      output irq, mask, nmi_req, INA, eoi,
      input  INT, NMI, INTD, in_service, active_vec
   );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-detected requests, serial vector delivery on
// acknowledge, in-service tracking and one level of NMI preemption.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | nothing requested or in service
// REQ       | INT raised, waiting for the core's acknowledge edge
// NMI_REQ   | NMI raised, waiting for the core's acknowledge edge
// SHIFT     | vector being shifted out on INTD, MSB first
// SVC       | maskable interrupt in service, waiting for eoi
// NMI_SVC   | NMI in service, waiting for eoi (returns to SVC when nested)
module interrupt_controller #(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   interrupt_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      NMI_REQ,
      SHIFT,
      SVC,
      NMI_SVC
   } state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] irq_d;
   logic               nmi_d;
   logic               ina_d;
   logic [NUM_IRQ-1:0] pending;
   logic               nmi_pend;
   logic               nested;
   logic [VEC_W-1:0]   shreg;
   logic [VEC_W-1:0]   bit_cnt;
   logic [VEC_W-1:0]   active_vec;

   logic [NUM_IRQ-1:0] irq_rise;
   logic               nmi_rise;
   logic               ina_rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [VEC_W-1:0]   grant_idx;
   logic               take_irq;
   logic               take_nmi;
   logic [NUM_IRQ-1:0] pend_clr;

   assign irq_rise = bus.irq & ~irq_d;
   assign nmi_rise = bus.nmi_req & ~nmi_d;
   assign ina_rise = bus.INA & ~ina_d;
   assign eligible = pending & ~bus.mask;

   // lowest index wins, so scan downwards and let the last hit stick
   always_comb begin
      grant_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) grant_idx = VEC_W'(i);
      end
   end

   assign take_irq = (state == REQ) && !nmi_pend && (eligible != '0) && ina_rise;
   assign take_nmi = (state == NMI_REQ) && ina_rise;
   assign pend_clr = take_irq ? (NUM_IRQ'(1) << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         irq_d      <= '0;
         nmi_d      <= 1'b0;
         ina_d      <= 1'b0;
         pending    <= '0;
         nmi_pend   <= 1'b0;
         nested     <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         active_vec <= '0;
      end else begin
         irq_d    <= bus.irq;
         nmi_d    <= bus.nmi_req;
         ina_d    <= bus.INA;
         // a new edge on the same cycle as the clear must survive
         pending  <= (pending & ~pend_clr) | irq_rise;
         nmi_pend <= (nmi_pend & ~take_nmi) | nmi_rise;

         unique case (state)
            IDLE: begin
               if (nmi_pend)               state <= NMI_REQ;
               else if (eligible != '0)    state <= REQ;
            end
            REQ: begin
               if (nmi_pend)               state <= NMI_REQ;
               else if (eligible == '0)    state <= IDLE;
               else if (ina_rise) begin
                  shreg      <= grant_idx;
                  active_vec <= grant_idx;
                  bit_cnt    <= VEC_W'(VEC_W - 1);
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_cnt == '0) begin
                  state <= SVC;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
               shreg <= shreg << 1;
            end
            SVC: begin
               if (bus.eoi) begin
                  state <= IDLE;
               end else if (nmi_pend) begin
                  nested <= 1'b1;
                  state  <= NMI_REQ;
               end
            end
            NMI_REQ: begin
               if (ina_rise) state <= NMI_SVC;
            end
            NMI_SVC: begin
               if (bus.eoi) begin
                  nested <= 1'b0;
                  state  <= nested ? SVC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.INT        = (state == REQ);
   assign bus.NMI        = (state == NMI_REQ);
   assign bus.INTD       = (state == SHIFT) && shreg[VEC_W-1];
   assign bus.in_service = (state == SVC) ||
                           (nested && ((state == NMI_REQ) || (state == NMI_SVC)));
   assign bus.active_vec = active_vec;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with hand-derived cycle timing.
module tb_interrupt_controller;
   localparam int NUM_IRQ = 8;
   localparam int VEC_W   = 3;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   interrupt_controller_if #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) bus ();

   interrupt_controller #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.irq = '0; bus.mask = '0; bus.nmi_req = 1'b0; bus.INA = 1'b0; bus.eoi = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   // pulse irq lines for one cycle and step to the point where INT should be up
   task automatic raise_irq(input logic [NUM_IRQ-1:0] lines);
      bus.irq = lines;
      tick();
      bus.irq = '0;
      tick();
   endtask

   task automatic run_ack(input logic [VEC_W-1:0] vec, input string name);
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      n_cmp++;
      if (bus.INT !== 1'b0) begin
         n_err++; $display("FAIL %s_int_drop: INT=%b expected 0", name, bus.INT);
      end
      for (int j = 0; j < VEC_W; j++) begin
         n_cmp++;
         if (bus.INTD !== vec[VEC_W-1-j]) begin
            n_err++; $display("FAIL %s_intd_bit%0d: INTD=%b expected %b", name, j, bus.INTD, vec[VEC_W-1-j]);
         end
         tick();
      end
      n_cmp++;
      if (bus.in_service !== 1'b1 || bus.active_vec !== vec || bus.INTD !== 1'b0) begin
         n_err++;
         $display("FAIL %s_svc: in_service=%b active_vec=%0d INTD=%b expected 1/%0d/0",
                  name, bus.in_service, bus.active_vec, bus.INTD, vec);
      end
   endtask

   task automatic pulse_eoi();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.nmi_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.irq  = NUM_IRQ'($urandom);
         bus.mask = NUM_IRQ'($urandom);
         bus.INA  = 1'($urandom);
         bus.eoi  = 1'($urandom);
         tick();
         n_cmp++;
         if ({bus.INT, bus.NMI, bus.INTD, bus.in_service, bus.active_vec} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: INT=%b NMI=%b INTD=%b in_service=%b active_vec=%0d expected all 0",
                     bus.INT, bus.NMI, bus.INTD, bus.in_service, bus.active_vec);
         end
      end
      bus.irq = '0; bus.mask = '0; bus.INA = 1'b0; bus.eoi = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (bus.INT !== 1'b0 || bus.NMI !== 1'b0) begin
            n_err++; $display("FAIL reset_release: INT=%b NMI=%b expected 0/0", bus.INT, bus.NMI);
         end
      end
   endtask

   task automatic test_single();
      apply_reset();
      bus.irq = NUM_IRQ'(1) << 5;
      tick();
      bus.irq = '0;
      n_cmp++;
      if (bus.INT !== 1'b0) begin
         n_err++; $display("FAIL single_int_early: INT=%b expected 0", bus.INT);
      end
      tick();
      n_cmp++;
      if (bus.INT !== 1'b1) begin
         n_err++; $display("FAIL single_int_high: INT=%b expected 1", bus.INT);
      end
      run_ack(3'd5, "single");
      pulse_eoi();
      n_cmp++;
      if (bus.in_service !== 1'b0) begin
         n_err++; $display("FAIL single_eoi: in_service=%b expected 0", bus.in_service);
      end
      tick();
      n_cmp++;
      if (bus.INT !== 1'b0) begin
         n_err++; $display("FAIL single_no_rerequest: INT=%b expected 0", bus.INT);
      end
   endtask

   task automatic test_priority();
      apply_reset();
      raise_irq((NUM_IRQ'(1) << 6) | (NUM_IRQ'(1) << 2));
      n_cmp++;
      if (bus.INT !== 1'b1) begin
         n_err++; $display("FAIL prio_int_high: INT=%b expected 1", bus.INT);
      end
      run_ack(3'd2, "prio_first");
      pulse_eoi();
      tick();
      n_cmp++;
      if (bus.INT !== 1'b1) begin
         n_err++; $display("FAIL prio_reassert: INT=%b expected 1", bus.INT);
      end
      run_ack(3'd6, "prio_second");
      pulse_eoi();
   endtask

   task automatic test_masking();
      apply_reset();
      bus.mask = NUM_IRQ'(1) << 3;
      bus.irq  = NUM_IRQ'(1) << 3;
      tick();
      bus.irq = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_cmp++;
         if (bus.INT !== 1'b0) begin
            n_err++; $display("FAIL mask_hold_c%0d: INT=%b expected 0", i, bus.INT);
         end
      end
      bus.mask = '0;
      tick();
      n_cmp++;
      if (bus.INT !== 1'b1) begin
         n_err++; $display("FAIL mask_unmask: INT=%b expected 1", bus.INT);
      end
      run_ack(3'd3, "mask");
      pulse_eoi();
      raise_irq(NUM_IRQ'(1) << 3);
      n_cmp++;
      if (bus.INT !== 1'b1) begin
         n_err++; $display("FAIL mask_req_again: INT=%b expected 1", bus.INT);
      end
      bus.mask = NUM_IRQ'(1) << 3;
      tick();
      n_cmp++;
      if (bus.INT !== 1'b0) begin
         n_err++; $display("FAIL mask_remask_drop: INT=%b expected 0", bus.INT);
      end
   endtask

   task automatic test_nmi();
      apply_reset();
      raise_irq(NUM_IRQ'(1) << 4);
      run_ack(3'd4, "nmi_base");
      bus.nmi_req = 1'b1;
      tick();
      bus.nmi_req = 1'b0;
      tick();
      n_cmp++;
      if (bus.NMI !== 1'b1 || bus.in_service !== 1'b1) begin
         n_err++; $display("FAIL nmi_preempt: NMI=%b in_service=%b expected 1/1", bus.NMI, bus.in_service);
      end
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      n_cmp++;
      if (bus.NMI !== 1'b0) begin
         n_err++; $display("FAIL nmi_ack: NMI=%b expected 0", bus.NMI);
      end
      tick(); tick();
      pulse_eoi();
      n_cmp++;
      if (bus.in_service !== 1'b1 || bus.active_vec !== 3'd4 || bus.NMI !== 1'b0) begin
         n_err++;
         $display("FAIL nmi_return: in_service=%b active_vec=%0d NMI=%b expected 1/4/0",
                  bus.in_service, bus.active_vec, bus.NMI);
      end
      tick();
      pulse_eoi();
      n_cmp++;
      if (bus.in_service !== 1'b0) begin
         n_err++; $display("FAIL nmi_final_eoi: in_service=%b expected 0", bus.in_service);
      end
      tick();
      n_cmp++;
      if (bus.INT !== 1'b0 || bus.NMI !== 1'b0) begin
         n_err++; $display("FAIL nmi_idle: INT=%b NMI=%b expected 0/0", bus.INT, bus.NMI);
      end

      bus.nmi_req = 1'b1;
      bus.irq     = NUM_IRQ'(1) << 1;
      tick();
      bus.nmi_req = 1'b0;
      bus.irq     = '0;
      tick();
      n_cmp++;
      if (bus.NMI !== 1'b1 || bus.INT !== 1'b0 || bus.in_service !== 1'b0) begin
         n_err++;
         $display("FAIL nmi_first: NMI=%b INT=%b in_service=%b expected 1/0/0",
                  bus.NMI, bus.INT, bus.in_service);
      end
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      pulse_eoi();
      tick();
      n_cmp++;
      if (bus.INT !== 1'b1 || bus.NMI !== 1'b0) begin
         n_err++; $display("FAIL nmi_then_irq: INT=%b NMI=%b expected 1/0", bus.INT, bus.NMI);
      end
      run_ack(3'd1, "nmi_irq1");
      pulse_eoi();
   endtask

   task automatic test_reset_mid_shift();
      apply_reset();
      raise_irq(NUM_IRQ'(1) << 7);
      bus.INA = 1'b1;
      tick();
      bus.INA = 1'b0;
      n_cmp++;
      if (bus.INTD !== 1'b1) begin
         n_err++; $display("FAIL midshift_intd: INTD=%b expected 1", bus.INTD);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.INT, bus.NMI, bus.INTD, bus.in_service, bus.active_vec} !== '0) begin
         n_err++;
         $display("FAIL midshift_async: INT=%b NMI=%b INTD=%b in_service=%b active_vec=%0d expected all 0",
                  bus.INT, bus.NMI, bus.INTD, bus.in_service, bus.active_vec);
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (bus.INT !== 1'b0 || bus.in_service !== 1'b0 || bus.INTD !== 1'b0) begin
            n_err++;
            $display("FAIL midshift_after_c%0d: INT=%b in_service=%b INTD=%b expected 0/0/0",
                     i, bus.INT, bus.in_service, bus.INTD);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.irq = '0; bus.mask = '0; bus.nmi_req = 1'b0; bus.INA = 1'b0; bus.eoi = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_masking();
      test_nmi();
      test_reset_mid_shift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
